psum_mem_arbiter: RTL and testbench

Single-port arbiter for the partial-sum accumulation SRAM in the convolution accelerator. It shares the one SRAM port between three requesters: the controller's accumulation read, the controller's write-back, and the host result readout. A small in-order write buffer absorbs write-backs that collide with reads, so the controller never stalls on a write. A starvation counter guarantees the host readout progresses while the MAC loop runs.

---
 rtl/psum_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_psum_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_mem_arbiter.sv
// Single-port SRAM arbiter for the partial-sum store: controller read, controller write-back
// (via an in-order write buffer) and host readout. Define PSUM_FWD_EN to forward buffer hits.
module psum_mem_arbiter #(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 32,
   parameter int WBUF_DEPTH    = 2,
   parameter int HOST_MAX_WAIT = 8
) (
   input  logic                              clk,
   input  logic                              rst_in,
   input  logic                              wr_req,
   input  logic [ADDR_W-1:0]                 wr_addr,
   input  logic [DATA_W-1:0]                 wr_data,
   input  logic                              rd_req,
   input  logic [ADDR_W-1:0]                 rd_addr,
   output logic                              rd_gnt,
   output logic                              rd_valid,
   output logic [DATA_W-1:0]                 rd_data,
   input  logic                              host_req,
   input  logic [ADDR_W-1:0]                 host_addr,
   output logic                              host_gnt,
   output logic                              host_valid,
   output logic [DATA_W-1:0]                 host_data,
   output logic                              sram_en,
   output logic                              sram_we,
   output logic [ADDR_W-1:0]                 sram_addr,
   output logic [DATA_W-1:0]                 sram_wdata,
   input  logic [DATA_W-1:0]                 sram_rdata,
   output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_count,
   output logic                              err_ovf
);

   localparam int CW = $clog2(WBUF_DEPTH+1);
   localparam int WW = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT+1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wentry_t;

   // entry 0 is always the oldest write; pops shift the queue down
   wentry_t [WBUF_DEPTH-1:0] wbuf;
   logic [CW-1:0]            count;
   logic [WW-1:0]            wait_cnt;
   logic [WBUF_DEPTH-1:0]    rd_hit_v, host_hit_v;
   logic                     rd_hit, host_hit, full, empty, starved;
   logic                     wr_path, rd_fwd, host_fwd, pop, push, direct, ovf;
   int                       push_idx;
   wentry_t                  in_entry;

   assign full     = (count == CW'(WBUF_DEPTH));
   assign empty    = (count == '0);
   assign starved  = host_req && (wait_cnt == WW'(HOST_MAX_WAIT));
   assign in_entry = '{addr: wr_addr, data: wr_data};

   for (genvar g = 0; g < WBUF_DEPTH; g++) begin : g_cmp
      assign rd_hit_v[g]   = (count > CW'(g)) && (wbuf[g].addr == rd_addr);
      assign host_hit_v[g] = (count > CW'(g)) && (wbuf[g].addr == host_addr);
   end
   assign rd_hit   = |rd_hit_v;
   assign host_hit = |host_hit_v;

   // Port ownership. A buffer hit either forwards (port falls to the write path)
   // or is refused while the head drains toward the matching entry.
   always_comb begin
      rd_gnt   = 1'b0;
      host_gnt = 1'b0;
      wr_path  = 1'b0;
      rd_fwd   = 1'b0;
      host_fwd = 1'b0;
      if (!rst_in) begin
         if (full && wr_req) begin
            wr_path = 1'b1;
         end else if (starved) begin
            if (host_hit) begin
               wr_path = 1'b1;
`ifdef PSUM_FWD_EN
               host_gnt = 1'b1;
               host_fwd = 1'b1;
`endif
            end else begin
               host_gnt = 1'b1;
            end
         end else if (rd_req) begin
            if (rd_hit) begin
               wr_path = 1'b1;
`ifdef PSUM_FWD_EN
               rd_gnt = 1'b1;
               rd_fwd = 1'b1;
`endif
            end else begin
               rd_gnt = 1'b1;
            end
         end else if (!empty || wr_req) begin
            wr_path = 1'b1;
         end else begin
            host_gnt = host_req;
         end
      end
   end

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      pop        = 1'b0;
      direct     = 1'b0;
      if (wr_path && !empty) begin
         sram_en    = 1'b1;
         sram_we    = 1'b1;
         sram_addr  = wbuf[0].addr;
         sram_wdata = wbuf[0].data;
         pop        = 1'b1;
      end else if (wr_path && wr_req) begin
         sram_en    = 1'b1;
         sram_we    = 1'b1;
         sram_addr  = wr_addr;
         sram_wdata = wr_data;
         direct     = 1'b1;
      end else if (rd_gnt && !rd_fwd) begin
         sram_en   = 1'b1;
         sram_addr = rd_addr;
      end else if (host_gnt && !host_fwd) begin
         sram_en   = 1'b1;
         sram_addr = host_addr;
      end
   end

   assign push     = wr_req && !direct && !rst_in;
   assign ovf      = push && full && !pop;
   assign push_idx = int'(count) - (pop ? 1 : 0);

   always_ff @(posedge clk) begin
      if (rst_in) begin
         wbuf       <= '0;
         count      <= '0;
         wait_cnt   <= '0;
         rd_valid   <= 1'b0;
         host_valid <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (push && (i == push_idx))
               wbuf[i] <= in_entry;
            else if (pop)
               wbuf[i] <= wbuf[(i < WBUF_DEPTH-1) ? i+1 : i];
         end
         count <= count + CW'(push && !ovf) - CW'(pop);
         if (host_req && !host_gnt)
            wait_cnt <= (wait_cnt == WW'(HOST_MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);
         else
            wait_cnt <= '0;
         rd_valid   <= rd_gnt;
         host_valid <= host_gnt;
         err_ovf    <= err_ovf | ovf;
      end
   end

`ifdef PSUM_FWD_EN
   logic [DATA_W-1:0] rd_fwd_data, host_fwd_data, rd_fwd_data_q, host_fwd_data_q;
   logic              rd_fwd_q, host_fwd_q;

   // higher index is younger, so the last match wins
   always_comb begin
      rd_fwd_data   = '0;
      host_fwd_data = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if (rd_hit_v[i])   rd_fwd_data   = wbuf[i].data;
         if (host_hit_v[i]) host_fwd_data = wbuf[i].data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         rd_fwd_q        <= 1'b0;
         host_fwd_q      <= 1'b0;
         rd_fwd_data_q   <= '0;
         host_fwd_data_q <= '0;
      end else begin
         rd_fwd_q        <= rd_fwd;
         host_fwd_q      <= host_fwd;
         rd_fwd_data_q   <= rd_fwd_data;
         host_fwd_data_q <= host_fwd_data;
      end
   end

   assign rd_data   = rd_valid   ? (rd_fwd_q   ? rd_fwd_data_q   : sram_rdata) : '0;
   assign host_data = host_valid ? (host_fwd_q ? host_fwd_data_q : sram_rdata) : '0;
`else
   assign rd_data   = rd_valid   ? sram_rdata : '0;
   assign host_data = host_valid ? sram_rdata : '0;
`endif

   assign wbuf_count = count;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Bench for psum_mem_arbiter: directed table, reset sequence, then random traffic
// against a queue-based reference model and a bench-side SRAM.
module tb_psum_mem_arbiter;
   localparam int ADDR_W = 20, DATA_W = 32, WBUF_DEPTH = 2, HOST_MAX_WAIT = 8;

   logic clk = 1'b0;
   logic rst_in = 1'b1;
   logic wr_req = 0, rd_req = 0, host_req = 0;
   logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0, host_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic rd_gnt, rd_valid, host_gnt, host_valid, sram_en, sram_we, err_ovf;
   logic [DATA_W-1:0] rd_data, host_data, sram_wdata;
   logic [DATA_W-1:0] sram_rdata = '0;
   logic [ADDR_W-1:0] sram_addr;
   logic [$clog2(WBUF_DEPTH+1)-1:0] wbuf_count;

   always #5 clk = ~clk;

   psum_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(WBUF_DEPTH),
                      .HOST_MAX_WAIT(HOST_MAX_WAIT)) dut (
      .clk(clk), .rst_in(rst_in),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
      .host_valid(host_valid), .host_data(host_data),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .wbuf_count(wbuf_count), .err_ovf(err_ovf));

   // bench-side SRAM, 16 words
   logic [DATA_W-1:0] mem [16];
   always @(posedge clk) begin
      if (sram_en && sram_we)  mem[sram_addr[3:0]] <= sram_wdata;
      if (sram_en && !sram_we) sram_rdata <= mem[sram_addr[3:0]];
   end

   int n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: pending writes in arrival order, committed memory image
   typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } w_t;
   w_t q[$];
   logic [DATA_W-1:0] cmem [16];
   int wcnt = 0;
   logic pend_rv = 0, pend_hv = 0;
   logic [DATA_W-1:0] pend_rd = '0, pend_hd = '0;

   function automatic logic [DATA_W-1:0] view(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v = cmem[a[3:0]];
      foreach (q[i]) if (q[i].a == a) v = q[i].d;
      return v;
   endfunction

   function automatic bit in_buf(input logic [ADDR_W-1:0] a);
      foreach (q[i]) if (q[i].a == a) return 1'b1;
      return 1'b0;
   endfunction

   typedef struct {
      logic rst, wr, rd, hr, rg, hg;
      logic [ADDR_W-1:0] wa, ra, ha;
      logic [DATA_W-1:0] wd;
      int cnt;
   } vec_t;

   function automatic vec_t mk(bit wr, int wa, int wd, bit rd, int ra, bit hr, int ha,
                               bit rg, bit hg, int cnt);
      vec_t v;
      v.rst = 0; v.wr = wr; v.wa = ADDR_W'(wa); v.wd = DATA_W'(wd);
      v.rd = rd; v.ra = ADDR_W'(ra); v.hr = hr; v.ha = ADDR_W'(ha);
      v.rg = rg; v.hg = hg; v.cnt = cnt;
      return v;
   endfunction

   // one clock: drive, check combinational port at negedge, check registered state after edge
   task automatic step(input vec_t v, input bit use_tbl);
      logic e_rg, e_hg, wpath, rf, hf, e_we, e_ren, dir, emp, ful;
      logic [DATA_W-1:0] rdv, hdv;
      w_t c;
      rst_in = v.rst; wr_req = v.wr; wr_addr = v.wa; wr_data = v.wd;
      rd_req = v.rd; rd_addr = v.ra; host_req = v.hr; host_addr = v.ha;
      @(negedge clk);
      e_rg = 0; e_hg = 0; wpath = 0; rf = 0; hf = 0; e_we = 0; dir = 0;
      emp = (q.size() == 0); ful = (q.size() == WBUF_DEPTH);
      rdv = view(v.ra); hdv = view(v.ha);
      c.a = v.wa; c.d = v.wd;
      if (!emp) c = q[0];
      if (!v.rst) begin
         if (ful && v.wr) wpath = 1;
         else if (v.hr && wcnt == HOST_MAX_WAIT) begin
            if (in_buf(v.ha)) begin
               wpath = 1;
`ifdef PSUM_FWD_EN
               e_hg = 1; hf = 1;
`endif
            end else e_hg = 1;
         end else if (v.rd) begin
            if (in_buf(v.ra)) begin
               wpath = 1;
`ifdef PSUM_FWD_EN
               e_rg = 1; rf = 1;
`endif
            end else e_rg = 1;
         end else if (!emp || v.wr) wpath = 1;
         else if (v.hr) e_hg = 1;
         e_we  = wpath && (!emp || v.wr);
         dir   = wpath && emp && v.wr;
         e_ren = (e_rg && !rf) || (e_hg && !hf);
         chk("rd_gnt", rd_gnt, e_rg);
         chk("host_gnt", host_gnt, e_hg);
         chk("sram_en", sram_en, e_we || e_ren);
         chk("sram_we", sram_we, e_we);
         if (e_we) begin
            chk("sram_wr_addr", sram_addr, c.a);
            chk("sram_wr_data", sram_wdata, c.d);
         end else if (e_ren) chk("sram_rd_addr", sram_addr, e_rg ? v.ra : v.ha);
         if (use_tbl) begin
            chk("tbl_rd_gnt", rd_gnt, v.rg);
            chk("tbl_host_gnt", host_gnt, v.hg);
         end
      end
      @(posedge clk); #1;
      if (v.rst) begin
         q.delete(); wcnt = 0; pend_rv = 0; pend_hv = 0;
      end else begin
         if (e_we) begin
            cmem[c.a[3:0]] = c.d;
            if (!emp) q.delete(0);
         end
         if (v.wr && !dir) q.push_back(w_t'{a: v.wa, d: v.wd});
         if (v.hr && !e_hg) wcnt = (wcnt < HOST_MAX_WAIT) ? wcnt + 1 : wcnt;
         else wcnt = 0;
         pend_rv = e_rg; pend_rd = rdv; pend_hv = e_hg; pend_hd = hdv;
      end
      chk("rd_valid", rd_valid, pend_rv);
      if (pend_rv) chk("rd_data", rd_data, pend_rd);
      chk("host_valid", host_valid, pend_hv);
      if (pend_hv) chk("host_data", host_data, pend_hd);
      chk("wbuf_count", wbuf_count, 64'(q.size()));
      chk("err_ovf", err_ovf, 0);
      if (use_tbl) chk("tbl_wbuf_count", wbuf_count, 64'(v.cnt));
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      foreach (mem[i]) mem[i] = '0;
      foreach (cmem[i]) cmem[i] = '0;

      //                wr wa  wd      rd ra  hr ha  rg hg cnt
      tbl.push_back(mk(1, 5, 'hA,     0, 0,  0, 0,  0, 0, 0));  // direct write
      tbl.push_back(mk(0, 0, 0,       0, 0,  0, 0,  0, 0, 0));
      tbl.push_back(mk(0, 0, 0,       1, 5,  0, 0,  1, 0, 0));
      tbl.push_back(mk(0, 0, 0,       0, 0,  0, 0,  0, 0, 0));  // rd_data 0xA
      tbl.push_back(mk(1, 3, 'h11,    1, 7,  0, 0,  1, 0, 1));  // collision
      tbl.push_back(mk(0, 0, 0,       0, 0,  0, 0,  0, 0, 0));
      tbl.push_back(mk(0, 0, 0,       0, 0,  0, 0,  0, 0, 0));
      tbl.push_back(mk(1, 8, 1,       1, 12, 0, 0,  1, 0, 1));  // forced drain run
      tbl.push_back(mk(1, 9, 2,       1, 12, 0, 0,  1, 0, 2));
      tbl.push_back(mk(1, 10, 3,      1, 12, 0, 0,  0, 0, 2));
      tbl.push_back(mk(1, 11, 4,      1, 12, 0, 0,  0, 0, 2));
      tbl.push_back(mk(0, 0, 0,       0, 0,  0, 0,  0, 0, 1));
      tbl.push_back(mk(0, 0, 0,       0, 0,  0, 0,  0, 0, 0));
      tbl.push_back(mk(1, 9, 'h55,    1, 12, 0, 0,  1, 0, 1));  // buffer hit
`ifdef PSUM_FWD_EN
      tbl.push_back(mk(0, 0, 0,       1, 9,  0, 0,  1, 0, 0));
`else
      tbl.push_back(mk(0, 0, 0,       1, 9,  0, 0,  0, 0, 0));
`endif
      tbl.push_back(mk(0, 0, 0,       1, 9,  0, 0,  1, 0, 0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 0, 0,    1, 12, 1, 2,  1, 0, 0));  // host starving
      tbl.push_back(mk(0, 0, 0,       1, 12, 1, 2,  0, 1, 0));  // 9th cycle
      tbl.push_back(mk(0, 0, 0,       0, 0,  0, 0,  0, 0, 0));
      tbl.push_back(mk(1, 1, 'h77,    1, 12, 0, 0,  1, 0, 1));
      tbl.push_back(mk(1, 2, 'h88,    1, 13, 0, 0,  1, 0, 2));

      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.rst = 1;
      step(rv, 0);
      foreach (tbl[i]) step(tbl[i], 1);

      // reset with two buffered writes: nothing committed, outputs cleared
      step(rv, 0);
      rst_in = 0; #1;
      chk("rst_rd_data", rd_data, 0);
      chk("rst_host_data", host_data, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_wdata", sram_wdata, 0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
      step(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0), 1);
      step(mk(0, 0, 0, 0, 0, 1, 2, 0, 1, 0), 1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);

      // random traffic over a small address space so hits and starvation occur
      for (int n = 0; n < 3000; n++) begin
         rv = mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 9) < 6, $urandom_range(0, 7), 0, 0, 0);
         if ($urandom_range(0, 299) == 0) begin
            rv.rst = 1; rv.wr = 0;
         end
         step(rv, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
